// File: rtl/hazard_stall_ctrl.sv
// Load-use / RAW hazard stall and branch-flush control for a 5-stage pipeline.
// Optional feature: define WB_SPLIT_CYCLE_EN to exclude the WB entry from hazard detection.
module hazard_stall_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic [4:0]  id_dst,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_cycles
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t      r_state;
  logic        r_ex_wr, r_mem_wr, r_wb_wr;
  logic [4:0]  r_ex_dst, r_mem_dst, r_wb_dst;
  logic [15:0] r_stall_cnt;

  logic w_hit_ex, w_hit_mem, w_hit_wb;
  logic w_hazard;
  logic w_stall;
  logic w_ex_load;

  // Register 0 is hard-wired, so a zero destination can never produce a dependency.
  function automatic logic f_match(input logic       wr,
                                   input logic [4:0] dst,
                                   input logic       uses_rs,
                                   input logic [4:0] rs,
                                   input logic       uses_rt,
                                   input logic [4:0] rt);
    f_match = wr && (dst != 5'd0) &&
              ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] cnt);
    f_sat_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  assign w_hit_ex  = f_match(r_ex_wr,  r_ex_dst,  id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign w_hit_mem = f_match(r_mem_wr, r_mem_dst, id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign w_hit_wb  = f_match(r_wb_wr,  r_wb_dst,  id_uses_rs, id_rs, id_uses_rt, id_rt);

`ifdef WB_SPLIT_CYCLE_EN
  // Register file writes in the first half-cycle, so a WB producer is already visible to ID.
  assign w_hazard = id_valid && (w_hit_ex || w_hit_mem);
`else
  assign w_hazard = id_valid && (w_hit_ex || w_hit_mem || w_hit_wb);
`endif

  assign w_stall   = w_hazard && !ex_branch_taken;
  assign w_ex_load = id_valid && id_reg_write && (id_dst != 5'd0) && !idex_bubble;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_wr   <= 1'b0;
      r_ex_dst  <= 5'd0;
      r_mem_wr  <= 1'b0;
      r_mem_dst <= 5'd0;
      r_wb_wr   <= 1'b0;
      r_wb_dst  <= 5'd0;
    end else begin
      r_wb_wr   <= r_mem_wr;
      r_wb_dst  <= r_mem_dst;
      r_mem_wr  <= r_ex_wr;
      r_mem_dst <= r_ex_dst;
      r_ex_wr   <= w_ex_load;
      r_ex_dst  <= w_ex_load ? id_dst : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN:   if (w_stall)  r_state <= ST_STALL;
        ST_STALL: if (!w_stall) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
      if (w_stall) r_stall_cnt <= f_sat_inc(r_stall_cnt);
    end
  end

  assign stall_cycles = r_stall_cnt;

endmodule
